// File: rtl/mips_alu_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: the R-type function
// codes it decodes and the state encoding of its sequencing FSM.
package mips_alu_pkg;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // True for the four codes that start an iterative operation.
    function automatic logic is_muldiv(input logic [5:0] f);
        return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
    endfunction

endpackage

// File: rtl/abs32.sv
// Conditional two's-complement negate. Used both to take operand magnitudes
// and to restore the sign of results.
module abs32 (
    input  logic [31:0] value,
    input  logic        neg,
    output logic [31:0] result
);

    assign result = neg ? (~value + 32'd1) : value;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit. Signed operations run on magnitudes
// through a radix-2 shift-add (multiply) or restoring shift-subtract
// (divide) datapath, then a single fix-up cycle restores the signs.
//
// Handshake: start is a one-cycle request sampled on a rising edge; it is
// accepted only while busy is low, and anything sampled while busy is high
// is dropped. done pulses for one cycle once hi/lo hold a multiply/divide
// result. MTHI/MTLO complete on the accepting edge with no busy and no done.
module mul_div_unit
    import mips_alu_pkg::*;
#(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  funct,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output state_t      fsm_state
);

    state_t      state;
    logic [5:0]  cnt;
    logic        is_mul;
    logic        div_zero;
    logic        neg_lo;
    logic        neg_hi;
    logic [31:0] acc_hi;
    logic [31:0] acc_lo;
    logic [31:0] opb;

    // Operand magnitudes: only the signed codes strip the sign.
    logic        signed_op;
    logic        s1;
    logic        s2;
    logic [31:0] mag_a;
    logic [31:0] mag_b;

    assign signed_op = (funct == F_MULT) || (funct == F_DIV);
    assign s1        = signed_op & op1[31];
    assign s2        = signed_op & op2[31];

    abs32 u_abs_a (.value(op1), .neg(s1), .result(mag_a));
    abs32 u_abs_b (.value(op2), .neg(s2), .result(mag_b));

    // One radix-2 step; the accumulator pair is shared by both operations.
    logic [32:0] add_sum;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [31:0] next_hi;
    logic [31:0] next_lo;

    assign add_sum = {1'b0, acc_hi} + {1'b0, opb};
    assign shifted = {acc_hi, acc_lo[31]};
    assign diff    = shifted - {1'b0, opb};

    // Next accumulator value for the current iteration.
    always_comb begin
        next_hi = acc_hi;
        next_lo = acc_lo;
        if (is_mul) begin
            if (acc_lo[0]) begin
                {next_hi, next_lo} = {add_sum, acc_lo[31:1]};
            end else begin
                {next_hi, next_lo} = {1'b0, acc_hi, acc_lo[31:1]};
            end
        end else if (!diff[32]) begin
            next_hi = diff[31:0];
            next_lo = {acc_lo[30:0], 1'b1};
        end else begin
            next_hi = shifted[31:0];
            next_lo = {acc_lo[30:0], 1'b0};
        end
    end

    // Sign restoration. A negated 64-bit product only carries into the
    // upper word when the lower word is zero; otherwise the upper word is
    // just inverted.
    logic [31:0] hi_fix;
    logic [31:0] lo_fix;
    logic [31:0] hi_res;
    logic [31:0] lo_res;

    abs32 u_fix_hi (.value(acc_hi), .neg(neg_hi), .result(hi_fix));
    abs32 u_fix_lo (.value(acc_lo), .neg(neg_lo), .result(lo_fix));

    assign hi_res = (is_mul && neg_hi && (acc_lo != 32'd0)) ? ~acc_hi : hi_fix;
    assign lo_res = div_zero ? 32'hFFFF_FFFF : lo_fix;

    // Sequencing FSM with the datapath and architectural registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= 6'd0;
            is_mul   <= 1'b0;
            div_zero <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            acc_hi   <= 32'd0;
            acc_lo   <= 32'd0;
            opb      <= 32'd0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (is_muldiv(funct)) begin
                            is_mul   <= ~funct[1];
                            div_zero <= funct[1] && (op2 == 32'd0);
                            neg_lo   <= s1 ^ s2;
                            neg_hi   <= funct[1] ? s1 : (s1 ^ s2);
                            acc_hi   <= 32'd0;
                            acc_lo   <= funct[1] ? mag_a : mag_b;
                            opb      <= funct[1] ? mag_b : mag_a;
                            cnt      <= 6'd0;
                            state    <= ST_RUN;
                        end else if (funct == F_MTHI) begin
                            hi <= op1;
                        end else if (funct == F_MTLO) begin
                            lo <= op1;
                        end
                    end
                end
                ST_RUN: begin
                    acc_hi <= next_hi;
                    acc_lo <= next_lo;
                    cnt    <= cnt + 6'd1;
                    if (cnt == 6'(ITER - 1)) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    hi    <= hi_res;
                    lo    <= lo_res;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Status outputs decoded from the state register.
    assign busy      = (state != ST_IDLE);
    assign fsm_state = state;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: an arithmetic reference model predicts
// hi/lo/busy/done every cycle, and literal expectations pin known results.
module tb_mul_div_unit;
    import mips_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  funct = 6'd0;
    logic [31:0] op1 = 32'd0;
    logic [31:0] op2 = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    state_t      fsm_state;

    int n_cmp = 0;
    int n_bad = 0;
    bit checking = 1'b0;

    mul_div_unit #(.ITER(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct(funct),
        .op1(op1), .op2(op2), .busy(busy), .done(done),
        .hi(hi), .lo(lo), .fsm_state(fsm_state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // reference arithmetic: returns {hi, lo}
    function automatic logic [63:0] ref_result(input logic [5:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'd0;
        case (f)
            F_MULTU: p = {32'd0, a} * {32'd0, b};
            F_MULT:  p = 64'(sa * sb);
            F_DIVU:  p = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            F_DIV: begin
                if (b == 32'd0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: p = 64'd0;
        endcase
        return p;
    endfunction

    // reference model: an accepted op completes 33 edges after acceptance
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic        m_done = 1'b0;
    int          m_left = 0;
    logic [63:0] m_pend = 64'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi = 32'd0; m_lo = 32'd0; m_done = 1'b0; m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    {m_hi, m_lo} = m_pend;
                    m_done = 1'b1;
                end
            end else if (start) begin
                if (funct == F_MULT || funct == F_MULTU || funct == F_DIV || funct == F_DIVU) begin
                    m_pend = ref_result(funct, op1, op2);
                    m_left = 33;
                end else if (funct == F_MTHI) begin
                    m_hi = op1;
                end else if (funct == F_MTLO) begin
                    m_lo = op1;
                end
            end
        end
    end

    // scoreboard: every cycle once out of initial reset
    always @(negedge clk) begin
        if (checking) begin
            check32("cyc_hi", hi, m_hi);
            check32("cyc_lo", lo, m_lo);
            check32("cyc_busy", {31'd0, busy}, {31'd0, (m_left != 0)});
            check32("cyc_done", {31'd0, done}, {31'd0, m_done});
        end
    end

    // driver tasks (called at a falling edge, return at a falling edge)
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; funct = f; op1 = a; op2 = b;
        @(negedge clk);
        start = 1'b0; funct = 6'd0; op1 = 32'd0; op2 = 32'd0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_timeout: got done=%b expected 1", name, done);
        end
    endtask

    task automatic expect_op(input string name, input logic [5:0] f, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp_hi,
                             input logic [31:0] exp_lo);
        issue(f, a, b);
        check32({name, "_busy"}, {31'd0, busy}, 32'd1);
        wait_done(name);
        check32({name, "_hi"}, hi, exp_hi);
        check32({name, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check32("rst_hi", hi, 32'd0);
        check32("rst_lo", lo, 32'd0);
        check32("rst_busy", {31'd0, busy}, 32'd0);
        check32("rst_done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checking = 1'b1;
        @(negedge clk);

        expect_op("multu_max",  F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        expect_op("mult_neg",   F_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
        expect_op("mult_negneg",F_MULT,  32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd0,         32'd6);
        expect_op("mult_lo0",   F_MULT,  32'h8000_0000, 32'd2,         32'hFFFF_FFFF, 32'd0);
        expect_op("div_neg",    F_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        expect_op("div_mixed",  F_DIV,   32'd100,       32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFF2);
        expect_op("divu_zero",  F_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF);
        expect_op("div_zero_s", F_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF);
        expect_op("div_ovf",    F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
        expect_op("divu_big",   F_DIVU,  32'hFFFF_FFFF, 32'd10,        32'd5,         32'h1999_9999);

        // MTHI writes at once; an unsupported code changes nothing
        issue(F_MTHI, 32'h1234_5678, 32'd0);
        check32("mthi_hi", hi, 32'h1234_5678);
        check32("mthi_busy", {31'd0, busy}, 32'd0);
        issue(6'b100000, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        check32("bad_funct_hi", hi, 32'h1234_5678);
        check32("bad_funct_lo", lo, 32'h1999_9999);
        check32("bad_funct_busy", {31'd0, busy}, 32'd0);

        // start while busy is dropped; MTLO right after done is accepted
        issue(F_MULTU, 32'd1000, 32'd3000);
        repeat (9) @(negedge clk);
        issue(F_MTLO, 32'd5, 32'd0);
        wait_done("busy_drop");
        check32("busy_drop_lo", lo, 32'd3_000_000);
        issue(F_MTLO, 32'd5, 32'd0);
        check32("mtlo_lo", lo, 32'd5);
        check32("mtlo_busy", {31'd0, busy}, 32'd0);
        check32("mtlo_done", {31'd0, done}, 32'd0);

        // reset in the middle of a divide
        issue(F_DIV, 32'd1000, 32'd7);
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check32("abort_hi", hi, 32'd0);
        check32("abort_lo", lo, 32'd0);
        check32("abort_busy", {31'd0, busy}, 32'd0);
        check32("abort_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        expect_op("post_rst", F_MULTU, 32'd3, 32'd4, 32'd0, 32'd12);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have parameter ITER, default 32, meaning the number of iteration cycles per multiply or divide; only 32 is supported.
REQ-002 Port clk SHALL be an input, 1 bit: the single rising-edge clock.
REQ-003 Port rst_n SHALL be an input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port start SHALL be an input, 1 bit: request valid, sampled on a rising clk edge.
REQ-005 Port funct SHALL be an input, 6 bits: R-type function code selecting the operation.
REQ-006 Port op1 SHALL be an input, 32 bits: rs value (multiplicand or dividend; source for MTHI/MTLO).
REQ-007 Port op2 SHALL be an input, 32 bits: rt value (multiplier or divisor).
REQ-008 Port busy SHALL be an output, 1 bit: high while an operation is in flight.
REQ-009 Port done SHALL be an output, 1 bit: one-cycle pulse marking that hi and lo were updated by MULT, MULTU, DIV or DIVU.
REQ-010 Ports hi and lo SHALL be outputs, 32 bits each: architectural HI and LO registers.

Function
REQ-011 Supported funct codes SHALL be: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MTHI 010001, MTLO 010011; all other codes with start=1 are ignored.
REQ-012 The FSM SHALL have three states: IDLE, RUN and FIX; busy = (state != IDLE).
REQ-013 In IDLE, start=1 with a multiply or divide funct sampled at edge k SHALL latch the operands, latch the operation type and signedness, and move to RUN.
REQ-014 Signed operations SHALL latch operand magnitudes and record the result signs; unsigned operations SHALL latch the operands unchanged.
REQ-015 RUN SHALL perform one radix-2 step per cycle at edges k+1 .. k+32, using a 6-bit iteration counter, then enter FIX.
- Multiply: shift-add.
- Divide: restoring shift-subtract.
REQ-016 FIX SHALL apply the sign correction and write hi and lo at edge k+33, pulse done high for exactly the following cycle, and return to IDLE.
- Multiply: hi = product[63:32], lo = product[31:0].
- Divide: lo = quotient, hi = remainder.
REQ-017 Signed divide SHALL set the quotient sign to sign(op1) XOR sign(op2) and the remainder sign to sign(op1).
REQ-018 Division by zero SHALL complete with normal latency and give lo = 32'hFFFF_FFFF, hi = op1 (original value).
REQ-019 Signed divide of 32'h8000_0000 by 32'hFFFF_FFFF SHALL give lo = 32'h8000_0000, hi = 0.
REQ-020 start sampled while busy=1 SHALL be ignored and SHALL leave hi, lo and state unchanged; no queuing.
REQ-021 MTHI or MTLO with start=1 in IDLE SHALL write op1 into hi or lo at that edge, keep busy low and not pulse done.
REQ-022 hi and lo SHALL hold their values at all times except on writes defined in REQ-016 and REQ-021.
REQ-023 The earliest next operation SHALL be accepted at edge k+34, giving a back-to-back throughput of one operation per 34 cycles.

Reset
REQ-024 While rst_n=0, state SHALL be IDLE and busy, done, hi, lo and all internal registers SHALL be 0, independent of clk.
REQ-025 Reset asserted mid-operation SHALL abort the operation with no partial hi/lo update; after release the block SHALL accept start on the first clk edge.

Structure
REQ-026 Funct code constants and the state enum SHALL live in the shared package mips_alu_pkg.
REQ-027 A sub-module abs32 (32-bit conditional two's-complement negate) SHALL be used for the operand magnitudes and the result sign fix; the iteration datapath SHALL stay in mul_div_unit.

Verification
REQ-028 MULTU op1=32'hFFFF_FFFF, op2=32'hFFFF_FFFF -> at edge k+33: hi=32'hFFFF_FFFE, lo=32'h0000_0001, done high for one cycle.
REQ-029 MULT op1=-3 (32'hFFFF_FFFD), op2=7 -> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB.
REQ-030 DIV op1=-7, op2=2 -> lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1); DIVU op1=100, op2=0 -> lo=32'hFFFF_FFFF, hi=100.
REQ-031 Second start (MTLO op1=5) at edge k+10 during a MULTU -> ignored; lo equals the product at k+33; a MTLO op1=5 at edge k+34 -> lo=5, busy stays low, no done.
REQ-032 rst_n pulsed low during cycle k+15 of a DIV -> hi=lo=0, busy=0, no done; a new MULTU 3x4 started after release -> lo=12 at 33 edges later.
